// File: rtl/seg_scan_if.sv
// seg_scan_if: load/value request side and display outputs of the
// multiplexed 7-segment driver, bundled for the CPU-to-pad boundary.
interface seg_scan_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
);
    logic              load;
    logic [DATA_W-1:0] value;
    logic              busy;
    logic              ovf;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;

    modport master (
        output load,
        output value,
        input  busy,
        input  ovf,
        input  seg,
        input  dig_en
    );

    modport slave (
        input  load,
        input  value,
        output busy,
        output ovf,
        output seg,
        output dig_en
    );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: bit-serial double-dabble BCD conversion feeding a
// time-multiplexed 7-segment scanner with zero blanking and overflow dashes.
module seg_scan_display #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned SCAN_DIV    = 1024,
    parameter int unsigned SEG_ACT_LOW = 0,
    parameter int unsigned DIG_ACT_LOW = 1,
    parameter int unsigned BLANK_LZ    = 1
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS - 1);
    localparam logic [6:0] DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF =
        (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] pval_q, pval_d;
    logic [BW-1:0]     wrk_q, wrk_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wovf_q, wovf_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;
    logic              cap;
    logic [DATA_W-1:0] cval;

    logic [PW-1:0]     pre_q;
    logic [IW-1:0]     idx_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              tc;
    logic [3:0]        nib;
    logic              lz;
    logic [6:0]        gly;
    logic [DIGITS-1:0] oh;

    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r[4*i +: 4] > 4'd4) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1110011;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // COMMIT chains straight into the next conversion when work is queued
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.load) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(DATA_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = (bus.load || pend_q) ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q != IDLE);
        bus.ovf    = ovf_q;
        bus.seg    = seg_q;
        bus.dig_en = dig_q;
    end

    always_comb begin
        sh_d   = sh_q;
        wrk_d  = wrk_q;
        wovf_d = wovf_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        pval_d = pval_q;
        disp_d = disp_q;
        ovf_d  = ovf_q;
        cap    = 1'b0;
        cval   = bus.value;
        unique case (state_q)
            IDLE: cap = bus.load;
            SHIFT: begin
                {wrk_d, sh_d} = {dabble(wrk_q), sh_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (bus.load) begin
                    pend_d = 1'b1;
                    pval_d = bus.value;
                end
            end
            COMMIT: begin
                disp_d = wrk_q;
                ovf_d  = wovf_q;
                cap    = bus.load || pend_q;
                cval   = bus.load ? bus.value : pval_q;
                pend_d = 1'b0;
            end
            default: ;
        endcase
        if (cap) begin
            sh_d   = cval;
            wrk_d  = '0;
            wovf_d = 32'(cval) > LIMIT;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            wrk_q  <= '0;
            wovf_q <= 1'b0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            pval_q <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            wrk_q  <= wrk_d;
            wovf_q <= wovf_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            pval_q <= pval_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    assign tc = (pre_q == PW'(SCAN_DIV - 1));

    // A digit is leading when it and every higher digit are zero
    always_comb begin
        nib = disp_q[4*idx_q +: 4];
        lz  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) lz = 1'b0;
        end
        if (ovf_q)
            gly = DASH;
        else if (BLANK_LZ != 0 && idx_q != '0 && lz)
            gly = 7'b0000000;
        else
            gly = glyph(nib);
        seg_d = (SEG_ACT_LOW != 0) ? ~gly : gly;
        oh    = DIGITS'(1) << idx_q;
        dig_d = (DIG_ACT_LOW != 0) ? ~oh : oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            pre_q <= tc ? '0 : pre_q + PW'(1);
            if (tc) begin
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
                seg_q <= seg_d;
                dig_q <= dig_d;
            end
        end
    end

endmodule
